// File: rtl/ssled_mux.sv
// Seven-segment scan driver: sequential double-dabble binary-to-BCD conversion
// feeding a multiplexed, brightness-controlled, leading-zero-blanked display.
module ssled_mux #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 16,
    parameter int REFRESH_DIV = 1024,
    parameter int BRIGHT_BITS = 2
) (
    input  logic                   clk_disp,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_score,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   blank_lz,
    input  logic [BRIGHT_BITS-1:0] bright,
    output logic [6:0]             seg,
    output logic [DIGITS-1:0]      an
);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SLICE = REFRESH_DIV >> BRIGHT_BITS;
    localparam longint unsigned MAXVAL = pow10(DIGITS) - 1;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t           r_state, w_state_next;
    logic             w_capture, w_done;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_acc, w_acc_adj, w_acc_next;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic [BW-1:0]    r_disp;
    logic             r_disp_ovf;
    logic [PW-1:0]    r_presc;
    logic [IW-1:0]    r_idx;
    logic [3:0]       w_nib;
    logic             w_upper_zero, w_lit, w_blank;
    logic [6:0]       w_seg;
    logic [DIGITS-1:0] w_an;

    always_ff @(posedge clk_disp) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == CW'(1)) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Add-3 correction on every nibble, then shift in the next binary bit
    always_comb begin
        w_acc_adj = r_acc;
        for (int d = 0; d < DIGITS; d++)
            if (r_acc[4*d +: 4] > 4'd4) w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
        w_acc_next = (w_acc_adj << 1) | BW'(r_shift[WIDTH-1]);
    end

    always_ff @(posedge clk_disp) begin
        if (w_capture) begin
            r_shift <= in_score;
            r_acc   <= '0;
            r_ovf   <= (64'(in_score) > MAXVAL);
            r_cnt   <= CW'(WIDTH);
        end else if (r_state == S_CONV) begin
            r_shift <= r_shift << 1;
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_disp) begin
        if (!rst_n) begin
            r_disp     <= '0;
            r_disp_ovf <= 1'b0;
        end else if (w_done) begin
            r_disp     <= w_acc_next;
            r_disp_ovf <= r_ovf;
        end
    end

    always_ff @(posedge clk_disp) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PW'(REFRESH_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Per-slot segment/anode evaluation from the current scan position
    always_comb begin
        w_nib        = 4'd0;
        w_upper_zero = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (IW'(d) == r_idx) w_nib = r_disp[4*d +: 4];
            if (d >= int'(r_idx) && r_disp[4*d +: 4] != 4'd0) w_upper_zero = 1'b0;
        end
        w_lit   = 32'(r_presc) < ((32'(bright) + 32'd1) * 32'(SLICE));
        w_blank = blank_lz && (r_idx != '0) && w_upper_zero && !r_disp_ovf;
        w_seg   = 7'h7F;
        w_an    = '1;
        if (w_lit && !w_blank) begin
            w_seg = r_disp_ovf ? 7'h3F : seg_decode(w_nib);
            for (int d = 0; d < DIGITS; d++) w_an[d] = !(IW'(d) == r_idx);
        end
    end

    always_ff @(posedge clk_disp) begin
        if (!rst_n) begin
            seg <= 7'h7F;
            an  <= '1;
        end else begin
            seg <= w_seg;
            an  <= w_an;
        end
    end

endmodule
